// File: rtl/jtag_param_dr.sv
// Parameterised JTAG test data register: capture, LSB-first shift, optional shadow update.
// The shadow register loads only when exactly WIDTH bits were shifted since the last capture.
module jtag_param_dr #(
   parameter int unsigned      WIDTH         = 32,
   parameter bit               CAPTURE_MODE  = 1'b0,
   parameter logic [WIDTH-1:0] CAPTURE_CONST = WIDTH'(32'h1000_1003),
   parameter bit               UPDATE_EN     = 1'b1,
   parameter logic [WIDTH-1:0] UPDATE_RST    = '0
) (
   input  logic             TCK,
   input  logic             TRST,
   input  logic             select,
   input  logic             capture_dr,
   input  logic             shift_dr,
   input  logic             update_dr,
   input  logic             tdi,
   input  logic [WIDTH-1:0] par_in,
   output logic             tdo,
   output logic [WIDTH-1:0] par_out,
   output logic             len_err
);

   localparam int unsigned CW       = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

   logic [WIDTH-1:0] shreg_q,   shreg_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic [WIDTH-1:0] par_out_q, par_out_d;
   logic             len_err_q, len_err_d;

   // Next-state: capture beats shift beats update; nothing moves unless selected.
   always_comb begin
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      par_out_d = par_out_q;
      len_err_d = len_err_q;
      if (select) begin
         if (capture_dr) begin
            shreg_d = CAPTURE_MODE ? par_in : CAPTURE_CONST;
            cnt_d   = {CW{1'b0}};
         end else if (shift_dr) begin
            shreg_d = {tdi, shreg_q[WIDTH-1:1]};
            // Saturating so an over-shift can never wrap back to a "valid" length.
            cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
         end else if (update_dr) begin
            if (UPDATE_EN) begin
               if (cnt_q == CNT_FULL) begin
                  par_out_d = shreg_q;
                  len_err_d = 1'b0;
               end else begin
                  len_err_d = 1'b1;
               end
            end else begin
               par_out_d = par_out_q;
            end
         end else begin
            shreg_d = shreg_q;
         end
      end else begin
         shreg_d = shreg_q;
      end
   end

   // State registers, cleared asynchronously by TRST.
   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST) begin
         shreg_q   <= {WIDTH{1'b0}};
         cnt_q     <= {CW{1'b0}};
         par_out_q <= UPDATE_RST;
         len_err_q <= 1'b0;
      end else begin
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         par_out_q <= par_out_d;
         len_err_q <= len_err_d;
      end
   end

   assign tdo     = shreg_q[0];
   assign par_out = par_out_q;
   assign len_err = len_err_q;

endmodule
